// File: rtl/riscv_if_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode output slot and redirect.
interface riscv_if_if #(
    parameter int unsigned XLEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            id_ready;
    logic            valid;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic            exception;

    modport master (
        input  redirect, redirect_pc,
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  id_ready,
        output valid, instruction, pc, exception
    );

    modport slave (
        output redirect, redirect_pc,
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output id_ready,
        input  valid, instruction, pc, exception
    );
endinterface

// File: rtl/riscv_if.sv
// RISC-V instruction fetch stage: single-outstanding imem requests, registered decode slot
// with a one-entry hold buffer, redirect flush and misaligned-target fault reporting.
module riscv_if #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
    input  logic       clk,
    input  logic       rst,
    riscv_if_if.master bus
);

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic            kill;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic            exc_q;

    logic            slot_free;
    logic            consume;
    logic            accept;
    logic            in_flight;
    logic            misaligned;
    logic [XLEN-1:0] pc_next;

    // Request/response bookkeeping shared by the sequential block
    always_comb begin
        slot_free  = !valid_q || bus.id_ready;
        consume    = valid_q && bus.id_ready;
        accept     = (state == S_REQ) && bus.imem_ready;
        // A request is (or is about to be) outstanding whose response must be swallowed
        in_flight  = accept
                   || ((state == S_WAIT)  && !bus.imem_rvalid)
                   || ((state == S_FAULT) && kill && !bus.imem_rvalid);
        misaligned = |bus.redirect_pc[1:0];
        pc_next    = fetch_pc + XLEN'(PC_STEP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            kill       <= 1'b0;
            hold_instr <= NOP;
            hold_pc    <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
            exc_q      <= 1'b0;
        end else if (bus.redirect) begin
            // Redirect wins over everything: flush slot and hold buffer, restart at target
            fetch_pc <= bus.redirect_pc;
            kill     <= in_flight;
            instr_q  <= NOP;
            if (misaligned) begin
                state   <= S_FAULT;
                valid_q <= 1'b1;
                exc_q   <= 1'b1;
                pc_q    <= bus.redirect_pc;
            end else begin
                state   <= in_flight ? S_WAIT : S_REQ;
                valid_q <= 1'b0;
                exc_q   <= 1'b0;
            end
        end else begin
            if (consume) begin
                valid_q <= 1'b0;
                exc_q   <= 1'b0;
                instr_q <= NOP;
            end

            case (state)
                S_REQ: begin
                    if (bus.imem_ready) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (slot_free) begin
                            valid_q  <= 1'b1;
                            exc_q    <= 1'b0;
                            instr_q  <= bus.imem_rdata;
                            pc_q     <= fetch_pc;
                            fetch_pc <= pc_next;
                            state    <= S_REQ;
                        end else begin
                            hold_instr <= bus.imem_rdata;
                            hold_pc    <= fetch_pc;
                            fetch_pc   <= pc_next;
                            state      <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (slot_free) begin
                        valid_q <= 1'b1;
                        exc_q   <= 1'b0;
                        instr_q <= hold_instr;
                        pc_q    <= hold_pc;
                        state   <= S_REQ;
                    end
                end

                S_FAULT: begin
                    // Stay parked until the next redirect; absorb a killed response meanwhile
                    if (kill && bus.imem_rvalid) begin
                        kill <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Request strobe follows the state so the first fetch issues right after reset release
    assign bus.imem_req    = rst && (state == S_REQ);
    assign bus.imem_addr   = fetch_pc;
    assign bus.valid       = valid_q;
    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.exception   = exc_q;

endmodule

// File: tb/tb_riscv_if.sv
// Self-checking bench for riscv_if: directed sequences, a redirect vector table and a
// randomized run scored against an in-order fetch-stream model.
module tb_riscv_if;

    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam logic [31:0] W0    = 32'h0050_0093;

    logic clk = 1'b0;
    logic rst = 1'b0;

    riscv_if_if #(.XLEN(XLEN)) bus ();

    riscv_if #(
        .XLEN    (XLEN),
        .RESET_PC(32'h0000_0000),
        .NOP     (NOP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // memory model configuration and state
    bit          mem_rand = 1'b0;
    int unsigned mem_lat  = 1;
    bit          pend     = 1'b0;
    int unsigned pend_cnt = 0;
    logic [31:0] pend_addr;

    typedef struct {
        logic [31:0] target;
        logic        exc;
        logic [31:0] next_addr;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return W0;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_for(input bit on_req, input int max_cyc, input string name);
        int i;
        i = 0;
        while (!(on_req ? bus.imem_req : bus.valid) && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        if (!(on_req ? bus.imem_req : bus.valid)) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, got 0 expected 1", name, max_cyc);
        end
    endtask

    // Instruction memory: one response per accepted request, latency >= 1 cycle
    always begin
        @(negedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        if (!rst) begin
            pend           = 1'b0;
            bus.imem_ready = 1'b1;
            bus.imem_rdata = 32'h0;
        end else begin
            if (pend) begin
                if (pend_cnt <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend_addr);
                    pend            = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            bus.imem_ready = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.imem_req) begin
                chk("single_outstanding", 32'(pend), 32'h0);
                if (bus.imem_ready) begin
                    pend      = 1'b1;
                    pend_addr = bus.imem_addr;
                    pend_cnt  = mem_rand ? $urandom_range(1, 3) : mem_lat;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] prev_pc, prev_instr;
        bit          prev_valid, prev_idr, prev_redir, redir, idr;
        int          n_cons;

        vecs[0] = '{32'h0000_0102, 1'b1, 32'h0};
        vecs[1] = '{32'h0000_0200, 1'b0, 32'h0000_0204};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'h0000_0003, 1'b1, 32'h0};
        vecs[4] = '{32'h0000_0040, 1'b0, 32'h0000_0044};
        vecs[5] = '{32'h7FFF_FFFE, 1'b1, 32'h0};
        vecs[6] = '{32'h0000_1000, 1'b0, 32'h0000_1004};

        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready    = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_instr", bus.instruction, NOP_W);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_exc", 32'(bus.exception), 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'h0);

        // first fetch: valid two cycles after release
        @(posedge clk);
        #2 rst = 1'b1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        chk("first_wait_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        chk("first_valid", 32'(bus.valid), 32'h1);
        chk("first_pc", bus.pc, 32'h0);
        chk("first_instr", bus.instruction, W0);
        chk("first_next_addr", bus.imem_addr, 32'h4);

        // backpressure: entry held, second response parked, no requests
        bus.id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.valid), 32'h1);
            chk("bp_pc", bus.pc, 32'h0);
            chk("bp_instr", bus.instruction, W0);
            chk("bp_req", 32'(bus.imem_req), 32'h0);
        end
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("bp_hold_valid", 32'(bus.valid), 32'h1);
        chk("bp_hold_pc", bus.pc, 32'h4);
        chk("bp_hold_instr", bus.instruction, mem_word(32'h4));
        chk("bp_resume_addr", bus.imem_addr, 32'h8);
        @(negedge clk);
        chk("bp_gap_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        chk("bp_next_pc", bus.pc, 32'h8);

        // redirect in WAIT before the response arrives
        mem_lat = 3;
        @(negedge clk);
        chk("wait_state_req", 32'(bus.imem_req), 32'h0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("redir_wait_flush", 32'(bus.valid), 32'h0);
        wait_for(1'b1, 10, "redir_wait_req");
        chk("redir_wait_addr", bus.imem_addr, 32'h0000_0100);
        mem_lat = 1;
        wait_for(1'b0, 10, "redir_wait_valid");
        chk("redir_wait_pc", bus.pc, 32'h0000_0100);
        chk("redir_wait_instr", bus.instruction, mem_word(32'h0000_0100));

        // redirect coinciding with rvalid while an entry is pending
        bus.id_ready = 1'b0;
        @(negedge clk);
        chk("pend_before_redir", bus.pc, 32'h0000_0100);
        chk("pend_valid_before_redir", 32'(bus.valid), 32'h1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0300;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("redir_rv_flush", 32'(bus.valid), 32'h0);
        chk("redir_rv_req", 32'(bus.imem_req), 32'h1);
        chk("redir_rv_addr", bus.imem_addr, 32'h0000_0300);
        bus.id_ready = 1'b1;
        wait_for(1'b0, 10, "redir_rv_valid");
        chk("redir_rv_pc", bus.pc, 32'h0000_0300);
        chk("redir_rv_instr", bus.instruction, mem_word(32'h0000_0300));

        // redirect target table: aligned fetches, wrap, misaligned faults
        foreach (vecs[v]) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = vecs[v].target;
            @(negedge clk);
            bus.redirect = 1'b0;
            chk("vec_valid", 32'(bus.valid), 32'(vecs[v].exc));
            chk("vec_exc", 32'(bus.exception), 32'(vecs[v].exc));
            if (vecs[v].exc) begin
                chk("vec_fault_pc", bus.pc, vecs[v].target);
                chk("vec_fault_instr", bus.instruction, NOP_W);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("vec_fault_noreq", 32'(bus.imem_req), 32'h0);
                end
                chk("vec_fault_consumed", 32'(bus.valid), 32'h0);
            end else begin
                wait_for(1'b0, 12, "vec_fetch_valid");
                chk("vec_pc", bus.pc, vecs[v].target);
                chk("vec_instr", bus.instruction, mem_word(vecs[v].target));
                chk("vec_fetch_exc", 32'(bus.exception), 32'h0);
                chk("vec_next_req", 32'(bus.imem_req), 32'h1);
                chk("vec_next_addr", bus.imem_addr, vecs[v].next_addr);
            end
        end

        // randomized run against the in-order fetch stream model
        mem_rand   = 1'b1;
        prev_valid = 1'b0;
        prev_idr   = 1'b0;
        prev_redir = 1'b0;
        prev_pc    = 32'h0;
        prev_instr = 32'h0;
        exp_pc     = 32'h0;
        tgt        = 32'h0;
        n_cons     = 0;
        for (int c = 0; c < 1500; c++) begin
            if (prev_redir) begin
                chk("rnd_redirect_flush", 32'(bus.valid), 32'h0);
            end else if (prev_valid && !prev_idr) begin
                chk("rnd_hold_valid", 32'(bus.valid), 32'h1);
                chk("rnd_hold_pc", bus.pc, prev_pc);
                chk("rnd_hold_instr", bus.instruction, prev_instr);
            end
            if (!bus.valid) chk("rnd_nop", bus.instruction, NOP_W);

            redir = (c == 0) || ($urandom_range(0, 15) == 0);
            idr   = ($urandom_range(0, 3) != 0);
            if (bus.valid && idr && !redir) begin
                chk("rnd_pc", bus.pc, exp_pc);
                chk("rnd_instr", bus.instruction, mem_word(exp_pc));
                chk("rnd_exc", 32'(bus.exception), 32'h0);
                exp_pc = exp_pc + 32'h4;
                n_cons++;
            end
            if (redir) begin
                tgt    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
                exp_pc = tgt;
            end
            bus.redirect    = redir;
            bus.redirect_pc = tgt;
            bus.id_ready    = idr;
            prev_redir = redir;
            prev_valid = bus.valid;
            prev_idr   = idr;
            prev_pc    = bus.pc;
            prev_instr = bus.instruction;
            @(negedge clk);
        end
        bus.redirect = 1'b0;
        mem_rand     = 1'b0;
        chk("rnd_progress", 32'(n_cons >= 40), 32'h1);

        // asynchronous reset while waiting on a response
        mem_lat         = 1;
        bus.id_ready    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0500;
        @(negedge clk);
        bus.redirect = 1'b0;
        wait_for(1'b0, 20, "pre_reset_fetch");
        mem_lat = 3;
        @(negedge clk);
        chk("pre_reset_valid", 32'(bus.valid), 32'h1);
        chk("pre_reset_pc", bus.pc, 32'h0000_0500);
        chk("pre_reset_wait", 32'(bus.imem_req), 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.valid), 32'h0);
        chk("async_rst_pc", bus.pc, 32'h0);
        chk("async_rst_instr", bus.instruction, NOP_W);
        chk("async_rst_exc", 32'(bus.exception), 32'h0);
        chk("async_rst_req", 32'(bus.imem_req), 32'h0);
        repeat (2) @(negedge clk);
        mem_lat = 1;
        @(posedge clk);
        #2 rst = 1'b1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        wait_for(1'b0, 10, "post_reset_valid");
        chk("post_reset_pc", bus.pc, 32'h0);
        chk("post_reset_instr", bus.instruction, W0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
